pipe_ctrl_regs: RTL and testbench
=================================

# pipe_ctrl_regs

Control-side pipeline register chain for the 5-stage PCPU. It carries decoded control fields from ID through EXE, MEM and WB, and inserts a bubble into EXE on a load-use stall. It is the source of the hazard-tracking inputs the ID-stage control/hazard unit consumes: `exe_regw_addr`, `exe_wreg`, `exe_mem2reg`, `mem_regw_addr`, `mem_wreg`, `mem_mem2reg`. It also provides retire and stall counters and a pipeline-empty flag for debug and bench checking.

## Interface
Parameters:
- CNT_W, 32, width of the retire and stall counters

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  reset; synchronous, active-low
- freeze  in  1  global hold (memory wait); all stages and counters hold
- stall  in  1  load-use stall from ID control; EXE receives a bubble
- id_valid  in  1  ID holds a real instruction (0 for cancelled slot)
- id_wreg, id_mem2reg, id_wmem, id_aluimm, id_shift, id_sext, id_jal  in  1 each  ID control bits
- id_aluc  in  4  ALU op
- id_regw_addr  in  5  destination register, already resolved by the regrt/jal select
- exe_valid, exe_wreg, exe_mem2reg, exe_wmem, exe_aluimm, exe_shift, exe_sext, exe_jal  out  1 each
- exe_aluc  out  4
- exe_regw_addr  out  5
- mem_valid, mem_wreg, mem_mem2reg, mem_wmem  out  1 each
- mem_regw_addr  out  5
- wb_valid, wb_wreg, wb_mem2reg  out  1 each
- wb_regw_addr  out  5
- pipe_empty  out  1  !exe_valid && !mem_valid && !wb_valid
- retire_cnt  out  CNT_W  instructions that left WB
- stall_cnt  out  CNT_W  cycles in which a stall bubble was inserted

## Operation
- Bubble: every field is 0, including valid, write enables, aluc and addr.
- EXE load value: a bubble if stall=1 or id_valid=0. Otherwise the ID fields, with these overrides:
  - exe_wreg is loaded as id_wreg && (id_regw_addr != 0). A write to $0 never appears as a forwarding source.
  - exe_mem2reg is loaded as id_mem2reg && (id_regw_addr != 0).
  - exe_wmem is loaded unmodified.
- Shift: MEM <= EXE fields (valid, wreg, mem2reg, wmem, regw_addr); WB <= MEM fields (valid, wreg, mem2reg, regw_addr).
- freeze=1: every stage register and both counters hold. stall is ignored, and no bubble or count is produced.
- Counters:
  - retire_cnt += 1 on each edge with freeze=0 && wb_valid=1.
  - stall_cnt += 1 on each edge with freeze=0 && stall=1 && id_valid=1.
  - Both wrap modulo 2^CNT_W with no saturation.
- The block does no forwarding muxing and no hazard detection; it only stores and shifts state.

## Timing
- Reset: on a clock edge with resetn=0, all stage registers go to bubble and both counters go to 0. After reset, pipe_empty=1.
- Reset mid-operation: any in-flight instructions are discarded in the same edge. resetn outranks freeze.
- Latency: an instruction accepted at ID in cycle n (freeze=0, stall=0, id_valid=1) is visible on exe_* in n+1, on mem_* in n+2 and on wb_* in n+3. Each freeze cycle adds one cycle at every stage it covers.
- All outputs are registered or derived only from registers (pipe_empty). There is no combinational path from any input to any output.
- stall and freeze together: freeze wins, nothing changes.
- During a stall, the stalled instruction stays in ID (holding the PC/IR is external). The EXE bubble propagates normally to MEM and WB.

## Test plan
- Reset: drive resetn=0 for 2 edges with random inputs. All outputs must read 0, pipe_empty=1, and both counters must read 0.
- Straight flow: present lw r5 (id_valid=1, id_wreg=1, id_mem2reg=1, id_regw_addr=5, id_aluc=ADD) for 1 cycle, then id_valid=0.
  - exe_regw_addr=5, exe_mem2reg=1 at +1.
  - mem_regw_addr=5, mem_mem2reg=1 at +2.
  - wb_regw_addr=5 at +3.
  - retire_cnt=1 after +4.
  - pipe_empty returns to 1 at +4.
- Load-use stall: lw r5, then add r6,r5,r5 held at ID with stall=1 for 1 cycle.
  - The cycle after the stall shows exe_valid=0, exe_wreg=0, mem_regw_addr=5, mem_mem2reg=1.
  - stall_cnt=1.
  - The add reaches EXE one cycle later with exe_regw_addr=6.
- Freeze: with three instructions in flight, hold freeze=1 for 3 cycles while toggling stall and id_*. All outputs and counters must be unchanged. Resuming must produce the original order.
- $0 destination: ori $0 with id_wreg=1 and id_regw_addr=0. exe_wreg must be 0 and exe_valid=1, and retire_cnt still increments when the instruction leaves WB.
- Reset mid-flight: drop resetn for 1 edge with all stages valid. All valid bits clear and both counters go to 0 on that edge, even with freeze=1.

Source files
------------

// File: rtl/pipe_ctrl_regs.sv
// Control-side pipeline registers ID->EXE->MEM->WB with load-use bubble insertion.
// Ports: clk/resetn (sync, active-low), freeze/stall holds, id_* in, exe_*/mem_*/wb_* out, counters.
module pipe_ctrl_regs #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             freeze,
    input  logic             stall,
    input  logic             id_valid,
    input  logic             id_wreg,
    input  logic             id_mem2reg,
    input  logic             id_wmem,
    input  logic             id_aluimm,
    input  logic             id_shift,
    input  logic             id_sext,
    input  logic             id_jal,
    input  logic [3:0]       id_aluc,
    input  logic [4:0]       id_regw_addr,
    output logic             exe_valid,
    output logic             exe_wreg,
    output logic             exe_mem2reg,
    output logic             exe_wmem,
    output logic             exe_aluimm,
    output logic             exe_shift,
    output logic             exe_sext,
    output logic             exe_jal,
    output logic [3:0]       exe_aluc,
    output logic [4:0]       exe_regw_addr,
    output logic             mem_valid,
    output logic             mem_wreg,
    output logic             mem_mem2reg,
    output logic             mem_wmem,
    output logic [4:0]       mem_regw_addr,
    output logic             wb_valid,
    output logic             wb_wreg,
    output logic             wb_mem2reg,
    output logic [4:0]       wb_regw_addr,
    output logic             pipe_empty,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic       wreg;
        logic       mem2reg;
        logic       wmem;
        logic       aluimm;
        logic       shift;
        logic       sext;
        logic       jal;
        logic [3:0] aluc;
        logic [4:0] rd;
    } exe_t;

    typedef struct packed {
        logic       valid;
        logic       wreg;
        logic       mem2reg;
        logic       wmem;
        logic [4:0] rd;
    } mem_t;

    typedef struct packed {
        logic       valid;
        logic       wreg;
        logic       mem2reg;
        logic [4:0] rd;
    } wb_t;

    exe_t exe_q, exe_d, exe_load;
    mem_t mem_q, mem_d;
    wb_t  wb_q, wb_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic rd_nz;

    assign rd_nz = (id_regw_addr != 5'd0);

    // Writes to $0 are stripped here so they never look like a forwarding source.
    always_comb begin
        exe_load = '0;
        if (id_valid && !stall) begin
            exe_load.valid   = 1'b1;
            exe_load.wreg    = id_wreg && rd_nz;
            exe_load.mem2reg = id_mem2reg && rd_nz;
            exe_load.wmem    = id_wmem;
            exe_load.aluimm  = id_aluimm;
            exe_load.shift   = id_shift;
            exe_load.sext    = id_sext;
            exe_load.jal     = id_jal;
            exe_load.aluc    = id_aluc;
            exe_load.rd      = id_regw_addr;
        end
    end

    always_comb begin
        exe_d    = exe_q;
        mem_d    = mem_q;
        wb_d     = wb_q;
        retire_d = retire_q;
        stall_d  = stall_q;
        if (!freeze) begin
            exe_d = exe_load;
            mem_d = '{valid:   exe_q.valid,
                      wreg:    exe_q.wreg,
                      mem2reg: exe_q.mem2reg,
                      wmem:    exe_q.wmem,
                      rd:      exe_q.rd};
            wb_d  = '{valid:   mem_q.valid,
                      wreg:    mem_q.wreg,
                      mem2reg: mem_q.mem2reg,
                      rd:      mem_q.rd};
            if (wb_q.valid)
                retire_d = retire_q + CNT_W'(1);
            if (stall && id_valid)
                stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            exe_q    <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            retire_q <= '0;
            stall_q  <= '0;
        end else begin
            exe_q    <= exe_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            retire_q <= retire_d;
            stall_q  <= stall_d;
        end
    end

    assign exe_valid     = exe_q.valid;
    assign exe_wreg      = exe_q.wreg;
    assign exe_mem2reg   = exe_q.mem2reg;
    assign exe_wmem      = exe_q.wmem;
    assign exe_aluimm    = exe_q.aluimm;
    assign exe_shift     = exe_q.shift;
    assign exe_sext      = exe_q.sext;
    assign exe_jal       = exe_q.jal;
    assign exe_aluc      = exe_q.aluc;
    assign exe_regw_addr = exe_q.rd;

    assign mem_valid     = mem_q.valid;
    assign mem_wreg      = mem_q.wreg;
    assign mem_mem2reg   = mem_q.mem2reg;
    assign mem_wmem      = mem_q.wmem;
    assign mem_regw_addr = mem_q.rd;

    assign wb_valid      = wb_q.valid;
    assign wb_wreg       = wb_q.wreg;
    assign wb_mem2reg    = wb_q.mem2reg;
    assign wb_regw_addr  = wb_q.rd;

    assign pipe_empty    = !exe_q.valid && !mem_q.valid && !wb_q.valid;
    assign retire_cnt    = retire_q;
    assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Bench for pipe_ctrl_regs: directed scenarios plus random traffic against
// a token-stream model (the pipeline as a 3-deep window over accepted slots).
module tb_pipe_ctrl_regs;

    logic        clk = 1'b0;
    logic        resetn, freeze, stall, id_valid;
    logic        id_wreg, id_mem2reg, id_wmem, id_aluimm, id_shift, id_sext, id_jal;
    logic [3:0]  id_aluc;
    logic [4:0]  id_regw_addr;
    logic        exe_valid, exe_wreg, exe_mem2reg, exe_wmem;
    logic        exe_aluimm, exe_shift, exe_sext, exe_jal;
    logic [3:0]  exe_aluc;
    logic [4:0]  exe_regw_addr;
    logic        mem_valid, mem_wreg, mem_mem2reg, mem_wmem;
    logic [4:0]  mem_regw_addr;
    logic        wb_valid, wb_wreg, wb_mem2reg;
    logic [4:0]  wb_regw_addr;
    logic        pipe_empty;
    logic [31:0] retire_cnt, stall_cnt;

    always #5 clk = ~clk;

    pipe_ctrl_regs #(.CNT_W(32)) dut (
        .clk(clk), .resetn(resetn), .freeze(freeze), .stall(stall),
        .id_valid(id_valid), .id_wreg(id_wreg), .id_mem2reg(id_mem2reg),
        .id_wmem(id_wmem), .id_aluimm(id_aluimm), .id_shift(id_shift),
        .id_sext(id_sext), .id_jal(id_jal), .id_aluc(id_aluc),
        .id_regw_addr(id_regw_addr),
        .exe_valid(exe_valid), .exe_wreg(exe_wreg), .exe_mem2reg(exe_mem2reg),
        .exe_wmem(exe_wmem), .exe_aluimm(exe_aluimm), .exe_shift(exe_shift),
        .exe_sext(exe_sext), .exe_jal(exe_jal), .exe_aluc(exe_aluc),
        .exe_regw_addr(exe_regw_addr),
        .mem_valid(mem_valid), .mem_wreg(mem_wreg), .mem_mem2reg(mem_mem2reg),
        .mem_wmem(mem_wmem), .mem_regw_addr(mem_regw_addr),
        .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_mem2reg(wb_mem2reg),
        .wb_regw_addr(wb_regw_addr),
        .pipe_empty(pipe_empty), .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic       v, w, m2r, wm, ai, sh, sx, jl;
        logic [3:0] aluc;
        logic [4:0] rd;
    } rec_t;

    rec_t        win[$];
    int unsigned m_ret, m_stl;
    int          nvec = 0;
    int          nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic rec_t slot(input int back);
        rec_t r = '0;
        if (win.size() > back) r = win[win.size() - 1 - back];
        return r;
    endfunction

    // Advance the model by one clock edge using the current inputs.
    task automatic model_edge();
        rec_t r;
        if (!resetn) begin
            win.delete();
            m_ret = 0;
            m_stl = 0;
        end else if (!freeze) begin
            if (slot(2).v) m_ret++;
            if (stall && id_valid) m_stl++;
            r = '0;
            if (id_valid && !stall) begin
                r.v    = 1'b1;
                r.w    = id_wreg && (id_regw_addr != 0);
                r.m2r  = id_mem2reg && (id_regw_addr != 0);
                r.wm   = id_wmem;
                r.ai   = id_aluimm;
                r.sh   = id_shift;
                r.sx   = id_sext;
                r.jl   = id_jal;
                r.aluc = id_aluc;
                r.rd   = id_regw_addr;
            end
            win.push_back(r);
            if (win.size() > 3) void'(win.pop_front());
        end
    endtask

    task automatic check_all();
        rec_t e, m, b;
        e = slot(0);
        m = slot(1);
        b = slot(2);
        chk("exe", {exe_valid, exe_wreg, exe_mem2reg, exe_wmem, exe_aluimm,
                    exe_shift, exe_sext, exe_jal, exe_aluc, exe_regw_addr}, e);
        chk("mem", {mem_valid, mem_wreg, mem_mem2reg, mem_wmem, mem_regw_addr},
            {m.v, m.w, m.m2r, m.wm, m.rd});
        chk("wb", {wb_valid, wb_wreg, wb_mem2reg, wb_regw_addr},
            {b.v, b.w, b.m2r, b.rd});
        chk("empty", pipe_empty, !(e.v || m.v || b.v));
        chk("retire", retire_cnt, m_ret);
        chk("stallc", stall_cnt, m_stl);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic rand_id();
        id_valid     = ($urandom_range(0, 3) != 0);
        id_wreg      = $urandom_range(0, 1);
        id_mem2reg   = $urandom_range(0, 1);
        id_wmem      = $urandom_range(0, 1);
        id_aluimm    = $urandom_range(0, 1);
        id_shift     = $urandom_range(0, 1);
        id_sext      = $urandom_range(0, 1);
        id_jal       = $urandom_range(0, 1);
        id_aluc      = 4'($urandom_range(0, 15));
        id_regw_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    endtask

    task automatic set_id(input logic v, input logic w, input logic m2r,
                          input logic [4:0] rd, input logic [3:0] aluc);
        id_valid = v; id_wreg = w; id_mem2reg = m2r; id_wmem = 1'b0;
        id_aluimm = 1'b1; id_shift = 1'b0; id_sext = 1'b1; id_jal = 1'b0;
        id_aluc = aluc; id_regw_addr = rd;
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        for (int i = 0; i < n; i++) begin
            freeze = $urandom_range(0, 1);
            stall  = $urandom_range(0, 1);
            rand_id();
            step();
        end
        resetn = 1'b1; freeze = 1'b0; stall = 1'b0;
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 4'd0);
    endtask

    initial begin
        resetn = 1'b0; freeze = 1'b0; stall = 1'b0;
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 4'd0);
        m_ret = 0; m_stl = 0;

        // reset with random inputs
        do_reset(2);
        chk("rst_empty", pipe_empty, 1'b1);
        chk("rst_ret", retire_cnt, 32'd0);
        chk("rst_valid", {exe_valid, mem_valid, wb_valid}, 3'b000);

        // straight flow: lw r5
        set_id(1'b1, 1'b1, 1'b1, 5'd5, 4'd2);
        step();
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 4'd0);
        chk("lw_exe", {exe_regw_addr, exe_mem2reg}, {5'd5, 1'b1});
        step();
        chk("lw_mem", {mem_regw_addr, mem_mem2reg}, {5'd5, 1'b1});
        step();
        chk("lw_wb", wb_regw_addr, 5'd5);
        step();
        chk("lw_ret", retire_cnt, 32'd1);
        chk("lw_empty", pipe_empty, 1'b1);

        // load-use stall
        do_reset(1);
        set_id(1'b1, 1'b1, 1'b1, 5'd5, 4'd2);
        step();
        set_id(1'b1, 1'b1, 1'b0, 5'd6, 4'd2);
        stall = 1'b1;
        step();
        chk("lu_bubble", {exe_valid, exe_wreg}, 2'b00);
        chk("lu_mem", {mem_regw_addr, mem_mem2reg}, {5'd5, 1'b1});
        chk("lu_cnt", stall_cnt, 32'd1);
        stall = 1'b0;
        step();
        chk("lu_add", {exe_valid, exe_regw_addr}, {1'b1, 5'd6});
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 4'd0);
        for (int i = 0; i < 4; i++) step();

        // freeze with three in flight
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 1'b1, 1'b0, 5'(10 + i), 4'(i));
            step();
        end
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stall = $urandom_range(0, 1);
            rand_id();
            step();
        end
        chk("frz_exe", exe_regw_addr, 5'd12);
        chk("frz_wb", wb_regw_addr, 5'd10);
        freeze = 1'b0; stall = 1'b0;
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 4'd0);
        for (int i = 0; i < 4; i++) step();

        // $0 destination
        set_id(1'b1, 1'b1, 1'b0, 5'd0, 4'd5);
        step();
        chk("r0_exe", {exe_valid, exe_wreg}, 2'b10);
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 4'd0);
        for (int i = 0; i < 4; i++) step();

        // reset mid-flight while frozen
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 1'b1, 1'b1, 5'(20 + i), 4'(i));
            step();
        end
        resetn = 1'b0; freeze = 1'b1;
        step();
        chk("mrst_valid", {exe_valid, mem_valid, wb_valid}, 3'b000);
        chk("mrst_cnt", {retire_cnt, stall_cnt}, 64'd0);
        resetn = 1'b1; freeze = 1'b0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            resetn = ($urandom_range(0, 199) != 0);
            freeze = ($urandom_range(0, 4) == 0);
            stall  = ($urandom_range(0, 3) == 0);
            rand_id();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
